// File: rtl/result_reporter_if.sv
// Byte stream from the result reporter to the RS232 transmitter (valid/ready).
interface result_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/result_reporter.sv
// Round-robin collector of search-module results, framed onto a byte stream.
// Define RESULT_REPORTER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module result_reporter #(
  parameter int         NUM_OF_TAPS    = 5,
  parameter int         NUM_OF_MODULES = 20,
  parameter logic [7:0] SYNC_BYTE      = 8'hFF,
  parameter int         IDX_W          = 5
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0]  co_buf,
  input  logic [NUM_OF_MODULES-1:0]                found,
  output logic [NUM_OF_MODULES-1:0]                res,
  result_reporter_if.master                        tx,
  output logic                                     busy,
  output logic [15:0]                              frames_sent
);
  localparam int PW = NUM_OF_TAPS*8;
`ifdef RESULT_REPORTER_CHECKSUM_EN
  localparam int LEN = NUM_OF_TAPS+3;
`else
  localparam int LEN = NUM_OF_TAPS+2;
`endif
  localparam int BW = $clog2(LEN+1);

  typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0] which, rr_ptr, gnt;
  logic [PW-1:0]    payload, gslice;
  logic [BW-1:0]    bidx;
  logic             xfer, last;

  assign xfer = tx.tx_valid & tx.tx_ready;
  assign last = (bidx == BW'(LEN-1));

  // Walk requesters from rr_ptr downward-priority so the last hit is the first set bit at/after rr_ptr.
  always_comb begin
    int j;
    logic [NUM_OF_MODULES-1:0] sh;
    gnt    = '0;
    gslice = '0;
    j      = 0;
    sh     = '0;
    for (int i = NUM_OF_MODULES-1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_OF_MODULES) j = j - NUM_OF_MODULES;
      sh = found >> j;
      if (sh[0]) begin
        gnt    = IDX_W'(j);
        gslice = PW'(co_buf >> (j*PW));
      end
    end
  end

`ifdef RESULT_REPORTER_CHECKSUM_EN
  logic [7:0] cksum, cks_nxt;
  always_comb begin
    cks_nxt = 8'(gnt);
    for (int t = 0; t < NUM_OF_TAPS; t++) cks_nxt = cks_nxt ^ gslice[t*8 +: 8];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|found) state_nxt = SEND;
      SEND:    if (xfer && last) state_nxt = ACK;
      ACK:     state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx.tx_valid = (state == SEND);
    tx.tx_data  = 8'h00;
    busy        = (state != IDLE);
    res         = '0;
    if (state == ACK) res = (NUM_OF_MODULES)'(1) << which;
    if (state == SEND) begin
      if (bidx == '0)            tx.tx_data = SYNC_BYTE;
      else if (bidx == BW'(1))   tx.tx_data = 8'(which);
`ifdef RESULT_REPORTER_CHECKSUM_EN
      else if (last)             tx.tx_data = cksum;
`endif
      else                       tx.tx_data = payload[7:0];
    end
  end

  // Payload is consumed from the bottom; shifting only once past the index byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      which       <= '0;
      rr_ptr      <= '0;
      payload     <= '0;
      bidx        <= '0;
      frames_sent <= '0;
`ifdef RESULT_REPORTER_CHECKSUM_EN
      cksum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|found) begin
          which   <= gnt;
          payload <= gslice;
          bidx    <= '0;
`ifdef RESULT_REPORTER_CHECKSUM_EN
          cksum   <= cks_nxt;
`endif
        end
        SEND: if (xfer) begin
          bidx <= bidx + 1'b1;
          if (bidx >= BW'(2)) payload <= payload >> 8;
        end
        ACK: begin
          frames_sent <= frames_sent + 16'd1;
          rr_ptr      <= (which == IDX_W'(NUM_OF_MODULES-1)) ? '0 : which + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
